urna_session_ctrl: RTL

Session and poll controller that sequences the electronic ballot-box tally datapath (`urnaeletronica`).
- During voting: collects one 4-digit vote per clerk authorization, with correct/confirm handshake and inactivity timeout. On confirm, streams the digits into the datapath on consecutive cycles.
- At poll close: steps the datapath readout codes to latch all totals. On clerk request: issues the clear code.
- Holds the datapath frozen (finish=1, control=3'b111) whenever no vote is being streamed, so idle cycles never advance the datapath vote FSM.

---
 rtl/urna_session_ctrl_pkg.sv | 33 +++
 rtl/urna_session_ctrl_if.sv | 40 ++++
 rtl/urna_digit_buffer.sv | 36 +++
 rtl/urna_session_ctrl.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/urna_session_ctrl_pkg.sv
// Shared types and constants for the ballot-box session controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package urna_pkg;

    typedef enum logic [2:0] {
        CLEAR,
        IDLE,
        ENTRY,
        CONFIRM,
        SEND,
        DONE,
        TALLY,
        RESULTS
    } state_t;

    // Datapath readout/clear codes driven on urna_control while finish=1
    localparam logic [2:0] CTRL_CLEAR     = 3'b000;
    localparam logic [2:0] CTRL_ISABELLA  = 3'b001;
    localparam logic [2:0] CTRL_CLAUDIO   = 3'b010;
    localparam logic [2:0] CTRL_FILIPE    = 3'b011;
    localparam logic [2:0] CTRL_GUILHERME = 3'b100;
    localparam logic [2:0] CTRL_NULO      = 3'b101;
    localparam logic [2:0] CTRL_HOLD      = 3'b111;

    localparam int NUM_DIGITS = 4;

    // Only decimal keypad codes form part of a vote
    function automatic logic is_decimal(input logic [3:0] d);
        return d <= 4'd9;
    endfunction

endpackage

// File: rtl/urna_session_ctrl_if.sv
// Keypad/clerk inputs, datapath drive and status outputs of the session controller.
// Latency: n/a (wiring only).
// Backpressure: none; all inputs are single-cycle pulses or levels.
interface urna_session_if;
    logic [3:0] key_digit;
    logic       key_strobe;
    logic       key_correct;
    logic       key_confirm;
    logic       auth;
    logic       close_poll;
    logic       clear_req;
    logic [3:0] urna_digit;
    logic       urna_valid;
    logic       urna_finish;
    logic [2:0] urna_control;
    logic       ready_for_voter;
    logic [2:0] digits_entered;
    logic       vote_done;
    logic       timeout_flag;
    logic       results_ready;
    logic [7:0] voters_count;

    // Controller side
    modport slave (
        input  key_digit, key_strobe, key_correct, key_confirm,
        input  auth, close_poll, clear_req,
        output urna_digit, urna_valid, urna_finish, urna_control,
        output ready_for_voter, digits_entered, vote_done, timeout_flag,
        output results_ready, voters_count
    );

    // Keypad/clerk side
    modport master (
        output key_digit, key_strobe, key_correct, key_confirm,
        output auth, close_poll, clear_req,
        input  urna_digit, urna_valid, urna_finish, urna_control,
        input  ready_for_voter, digits_entered, vote_done, timeout_flag,
        input  results_ready, voters_count
    );
endinterface

// File: rtl/urna_digit_buffer.sv
// Four-entry append buffer holding the digits of the vote being entered.
// Latency: append visible on count_o the cycle after push_i; dout_o is combinational on rd_idx_i.
// Backpressure: pushes beyond NUM_DIGITS are dropped; clr_i wins over push_i.
module urna_digit_buffer
    import urna_pkg::*;
(
    input  logic       clock,
    input  logic       reset_n,
    input  logic       clr_i,
    input  logic       push_i,
    input  logic [3:0] din_i,
    input  logic [1:0] rd_idx_i,
    output logic [2:0] count_o,
    output logic [3:0] dout_o
);
    localparam logic [2:0] FULL_CNT = 3'(NUM_DIGITS);

    logic [3:0] mem_q [NUM_DIGITS];
    logic [2:0] count_q;

    // Append in entry order; clear only rewinds the count
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
            for (int i = 0; i < NUM_DIGITS; i++) mem_q[i] <= '0;
        end else if (clr_i) begin
            count_q <= '0;
        end else if (push_i && (count_q < FULL_CNT)) begin
            mem_q[count_q[1:0]] <= din_i;
            count_q             <= count_q + 3'd1;
        end
    end

    assign count_o = count_q;
    assign dout_o  = mem_q[rd_idx_i];
endmodule

// File: rtl/urna_session_ctrl.sv
// Session/poll sequencer for the urnaeletronica tally datapath (option: URNA_VOTER_LIMIT_EN).
// Latency: outputs registered from the current state; confirm at edge t -> digits t+1..t+4, vote_done after t+5.
// Backpressure: none; keypad/clerk pulses outside their accepting states are dropped.
module urna_session_ctrl
    import urna_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int TO_W           = 10,
    parameter int MAX_VOTERS     = 200
) (
    input  logic           clock,
    input  logic           reset_n,
    urna_session_if.slave  sess
);
    localparam logic [TO_W-1:0] TO_LAST    = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [2:0]      LAST_DIGIT = 3'(NUM_DIGITS - 1);
    localparam logic [2:0]      TALLY_LAST = CTRL_NULO - CTRL_ISABELLA;

`ifdef URNA_VOTER_LIMIT_EN
    localparam bit LIMIT_EN = 1'b1;
`else
    localparam bit LIMIT_EN = 1'b0;
`endif

    state_t          state_q, state_d;
    logic [2:0]      idx_q, idx_d;
    logic [TO_W-1:0] to_q, to_d;
    logic            close_pend_q, close_pend_d;
    logic            buf_clr, buf_push, abort, key_ok, limit_hit;
    logic [2:0]      buf_count;
    logic [3:0]      buf_dout;

    logic [3:0] digit_q;
    logic       valid_q, finish_q, vote_done_q, timeout_q, ready_q, results_q;
    logic [2:0] control_q;
    logic [7:0] voters_q;

    urna_digit_buffer u_buf (
        .clock    (clock),
        .reset_n  (reset_n),
        .clr_i    (buf_clr),
        .push_i   (buf_push),
        .din_i    (sess.key_digit),
        .rd_idx_i (idx_q[1:0]),
        .count_o  (buf_count),
        .dout_o   (buf_dout)
    );

    assign limit_hit = LIMIT_EN && (voters_q == 8'(MAX_VOTERS));
    assign key_ok    = sess.key_strobe && is_decimal(sess.key_digit);

    // Next-state: session sequencing, inactivity timer, deferred poll close
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        to_d         = to_q;
        close_pend_d = close_pend_q;
        buf_clr      = 1'b0;
        buf_push     = 1'b0;
        abort        = 1'b0;
        case (state_q)
            CLEAR: state_d = IDLE;
            IDLE: begin
                if (sess.close_poll) begin
                    state_d = TALLY;
                    idx_d   = '0;
                end else if (sess.auth && !limit_hit) begin
                    state_d = ENTRY;
                    buf_clr = 1'b1;
                    to_d    = '0;
                end
            end
            ENTRY: begin
                if (sess.close_poll) close_pend_d = 1'b1;
                if (sess.key_correct) begin
                    buf_clr = 1'b1;
                    to_d    = '0;
                end else if (key_ok) begin
                    buf_push = 1'b1;
                    to_d     = '0;
                    if (buf_count == LAST_DIGIT) state_d = CONFIRM;
                end else if (to_q == TO_LAST) begin
                    abort = 1'b1;
                end else begin
                    to_d = to_q + 1'b1;
                end
            end
            CONFIRM: begin
                if (sess.close_poll) close_pend_d = 1'b1;
                if (sess.key_correct) begin
                    state_d = ENTRY;
                    buf_clr = 1'b1;
                    to_d    = '0;
                end else if (sess.key_confirm) begin
                    state_d = SEND;
                    idx_d   = '0;
                end else if (to_q == TO_LAST) begin
                    abort = 1'b1;
                end else begin
                    to_d = to_q + 1'b1;
                end
            end
            SEND: begin
                if (sess.close_poll) close_pend_d = 1'b1;
                idx_d = idx_q + 3'd1;
                if (idx_q == LAST_DIGIT) state_d = DONE;
            end
            DONE: begin
                if (sess.close_poll) close_pend_d = 1'b1;
                buf_clr = 1'b1;
                idx_d   = '0;
                state_d = close_pend_d ? TALLY : IDLE;
            end
            TALLY: begin
                idx_d = idx_q + 3'd1;
                if (idx_q == TALLY_LAST) state_d = RESULTS;
            end
            RESULTS: if (sess.clear_req) state_d = CLEAR;
            default: state_d = CLEAR;
        endcase
        // An aborted session consumes the authorization; a pending close still applies
        if (abort) begin
            buf_clr = 1'b1;
            idx_d   = '0;
            state_d = close_pend_d ? TALLY : IDLE;
        end
        if (state_d == TALLY) close_pend_d = 1'b0;
    end

    // State register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= CLEAR;
            idx_q        <= '0;
            to_q         <= '0;
            close_pend_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            to_q         <= to_d;
            close_pend_q <= close_pend_d;
        end
    end

    // Registered outputs; datapath stays frozen (finish=1) except while streaming
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            digit_q     <= '0;
            valid_q     <= 1'b0;
            finish_q    <= 1'b1;
            control_q   <= CTRL_HOLD;
            vote_done_q <= 1'b0;
            timeout_q   <= 1'b0;
            ready_q     <= 1'b0;
            results_q   <= 1'b0;
            voters_q    <= '0;
        end else begin
            valid_q     <= (state_q == SEND);
            finish_q    <= (state_q != SEND);
            digit_q     <= (state_q == SEND) ? buf_dout : 4'd0;
            control_q   <= (state_q == CLEAR) ? CTRL_CLEAR :
                           (state_q == TALLY) ? (CTRL_ISABELLA + idx_q) : CTRL_HOLD;
            vote_done_q <= (state_q == DONE);
            timeout_q   <= abort;
            ready_q     <= (state_q == IDLE) && !limit_hit;
            results_q   <= (state_q == RESULTS);
            if (state_q == CLEAR)
                voters_q <= '0;
            else if ((state_q == DONE) && (voters_q != 8'hFF))
                voters_q <= voters_q + 8'd1;
        end
    end

    assign sess.urna_digit      = digit_q;
    assign sess.urna_valid      = valid_q;
    assign sess.urna_finish     = finish_q;
    assign sess.urna_control    = control_q;
    assign sess.ready_for_voter = ready_q;
    assign sess.digits_entered  = buf_count;
    assign sess.vote_done       = vote_done_q;
    assign sess.timeout_flag    = timeout_q;
    assign sess.results_ready   = results_q;
    assign sess.voters_count    = voters_q;
endmodule
